i2c_target_ctrl: RTL and testbench



---
 rtl/i2c_target_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_i2c_target_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_ctrl.sv
`timescale 1ns/1ps
// I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match,
// byte receive for writes and byte transmit for reads over open-drain SDA.
module i2c_target_ctrl #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       nack,
    output logic       rw,
    output logic       busy,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        WRITE     = 4'd3,
        WRITE_ACK = 4'd4,
        READ      = 4'd5,
        READ_ACK  = 4'd6,
        WAIT_STOP = 4'd7
    } state_t;

    state_t                 st;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   byte_done;
    logic                   master_nack;

    // Synchronizers reset to the idle-bus level so release of reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        scl_s    = scl_sync[SYNC_STAGES-1];
        sda_s    = sda_sync[SYNC_STAGES-1];
        scl_rise = scl_s & ~scl_d;
        scl_fall = ~scl_s & scl_d;
        start_c  = scl_s & scl_d & sda_d & ~sda_s;
        stop_c   = scl_s & scl_d & ~sda_d & sda_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            master_nack <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            nack        <= 1'b0;
            rw          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            nack     <= 1'b0;
            if (start_c) begin
                st        <= ADDR;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_c) begin
                st        <= IDLE;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (st)
                    IDLE: sda_oe <= 1'b0;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            // General call (address 0) is never acknowledged.
                            if (shreg[7:1] == TARGET_ADDR && shreg[7:1] != 7'd0) begin
                                rw     <= shreg[0];
                                st     <= ADDR_ACK;
                                sda_oe <= 1'b1;
                            end else begin
                                st     <= WAIT_STOP;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shreg   <= tx_data;
                                tx_load <= 1'b1;
                                sda_oe  <= ~tx_data[7];
                                st      <= READ;
                            end else begin
                                sda_oe <= 1'b0;
                                st     <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg[6:0], sda_s};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            st        <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            st     <= WRITE;
                        end
                    end
                    READ: begin
                        // MSB is already on the bus; each fall advances one bit.
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                st     <= READ_ACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s;
                            nack        <= sda_s;
                        end else if (scl_fall) begin
                            if (master_nack) begin
                                st <= WAIT_STOP;
                            end else begin
                                shreg   <= tx_data;
                                tx_load <= 1'b1;
                                sda_oe  <= ~tx_data[7];
                                bit_cnt <= '0;
                                st      <= READ;
                            end
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default: begin
                        st     <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;
    assign busy  = (st != IDLE);
endmodule

// File: tb/tb_i2c_target_ctrl.sv
`timescale 1ns/1ps
// Directed bench: an I2C master model drives SCL/SDA against the target,
// checking ACKs, received/transmitted bytes, pulses and reset behaviour.
module tb_i2c_target_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_load, nack, rw, busy;
    logic [7:0] rx_data;
    logic [3:0] state;
    logic       sda_bus;

    int vectors = 0, errors = 0;
    int cnt_rx = 0, cnt_txl = 0, cnt_nack = 0, cnt_oe = 0, cnt_bad = 0;
    int s_rx, s_txl, s_nack, s_oe;
    logic       bv, ov;
    logic [7:0] rb;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_ctrl #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .nack(nack), .rw(rw),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) cnt_rx <= cnt_rx + 1;
        if (tx_load)  cnt_txl <= cnt_txl + 1;
        if (nack)     cnt_nack <= cnt_nack + 1;
        if (sda_oe)   cnt_oe <= cnt_oe + 1;
        if (sda_oe && (state == 4'd0 || state == 4'd7)) cnt_bad <= cnt_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #100;
        scl = 1'b1;   #100;
        sda_m = 1'b0; #100;
        scl = 1'b0;   #100;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #100;
        scl = 1'b1;   #100;
        sda_m = 1'b1; #100;
    endtask

    // One SCL clock; bus level and sda_oe sampled mid-high.
    task automatic clk_bit(input logic b, output logic bus_v, output logic oe_v);
        sda_m = b; #100;
        scl = 1'b1; #100;
        bus_v = sda_bus;
        oe_v  = sda_oe;
        #100;
        scl = 1'b0; #100;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic x, y;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], x, y);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic y;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, b[i], y);
    endtask

    initial begin
        #33;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_outs", {24'd0, sda_oe, rx_valid, tx_load, nack, rw, busy, 2'b00}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        #67 rst_n = 1'b1;
        #200;

        // Write 0x3C
        s_rx = cnt_rx;
        i2c_start();
        check("start_addr_state", {28'd0, state}, 32'd1);
        send_byte(8'hA0);
        clk_bit(1'b1, bv, ov);
        check("wr_addr_ack_oe", {31'd0, ov}, 32'd1);
        check("wr_addr_ack_bus", {31'd0, bv}, 32'd0);
        check("wr_rw", {31'd0, rw}, 32'd0);
        send_byte(8'h3C);
        clk_bit(1'b1, bv, ov);
        check("wr_data_ack_oe", {31'd0, ov}, 32'd1);
        check("wr_rx_data", {24'd0, rx_data}, 32'h3C);
        check("wr_rx_valid_cnt", cnt_rx - s_rx, 32'd1);
        i2c_stop();
        #100;
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

        // Address mismatch
        s_rx = cnt_rx; s_txl = cnt_txl; s_oe = cnt_oe;
        i2c_start();
        send_byte(8'hA4);
        clk_bit(1'b1, bv, ov);
        check("mm_ack_bus", {31'd0, bv}, 32'd1);
        check("mm_state", {28'd0, state}, 32'd7);
        send_byte(8'h55);
        check("mm_state_held", {28'd0, state}, 32'd7);
        check("mm_oe_cycles", cnt_oe - s_oe, 32'd0);
        check("mm_rx_txl", (cnt_rx - s_rx) + (cnt_txl - s_txl), 32'd0);
        check("mm_rx_data_held", {24'd0, rx_data}, 32'h3C);
        i2c_stop();
        #100;
        check("mm_idle", {28'd0, state}, 32'd0);

        // Read 0xA5, ACK, 0x0F, NACK
        s_txl = cnt_txl; s_nack = cnt_nack;
        tx_data = 8'hA5;
        i2c_start();
        send_byte(8'hA1);
        clk_bit(1'b1, bv, ov);
        check("rd_addr_ack_oe", {31'd0, ov}, 32'd1);
        check("rd_rw", {31'd0, rw}, 32'd1);
        check("rd_tx_load_1", cnt_txl - s_txl, 32'd1);
        tx_data = 8'h0F;
        recv_byte(rb);
        check("rd_byte_a5", {24'd0, rb}, 32'hA5);
        check("rd_state_ack", {28'd0, state}, 32'd6);
        clk_bit(1'b0, bv, ov);
        check("rd_tx_load_2", cnt_txl - s_txl, 32'd2);
        tx_data = 8'h77;
        recv_byte(rb);
        check("rd_byte_0f", {24'd0, rb}, 32'h0F);
        clk_bit(1'b1, bv, ov);
        check("rd_nack_cnt", cnt_nack - s_nack, 32'd1);
        check("rd_nack_oe", {31'd0, sda_oe}, 32'd0);
        check("rd_nack_state", {28'd0, state}, 32'd7);
        check("rd_no_extra_load", cnt_txl - s_txl, 32'd2);
        i2c_stop();
        #100;

        // Repeated START inside a write byte, then a read
        s_rx = cnt_rx; s_txl = cnt_txl;
        i2c_start();
        send_byte(8'hA0);
        clk_bit(1'b1, bv, ov);
        clk_bit(1'b1, bv, ov);
        clk_bit(1'b0, bv, ov);
        clk_bit(1'b1, bv, ov);
        i2c_start();
        check("rs_state_addr", {28'd0, state}, 32'd1);
        check("rs_no_rx_valid", cnt_rx - s_rx, 32'd0);
        tx_data = 8'h3C;
        send_byte(8'hA1);
        clk_bit(1'b1, bv, ov);
        check("rs_addr_ack_oe", {31'd0, ov}, 32'd1);
        recv_byte(rb);
        check("rs_read_byte", {24'd0, rb}, 32'h3C);
        clk_bit(1'b1, bv, ov);
        check("rs_tx_load_cnt", cnt_txl - s_txl, 32'd1);
        i2c_stop();
        #100;

        // Back-to-back writes
        s_rx = cnt_rx;
        i2c_start();
        send_byte(8'hA0);
        clk_bit(1'b1, bv, ov);
        send_byte(8'h01);
        clk_bit(1'b1, bv, ov);
        check("b2b_rx_01", {24'd0, rx_data}, 32'h01);
        check("b2b_cnt_1", cnt_rx - s_rx, 32'd1);
        send_byte(8'hFF);
        clk_bit(1'b1, bv, ov);
        check("b2b_ack2_oe", {31'd0, ov}, 32'd1);
        check("b2b_rx_ff", {24'd0, rx_data}, 32'hFF);
        check("b2b_cnt_2", cnt_rx - s_rx, 32'd2);
        i2c_stop();
        #100;

        // Asynchronous reset while driving a read bit low
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'hA1);
        clk_bit(1'b1, bv, ov);
        check("rst_pre_state", {28'd0, state}, 32'd5);
        check("rst_pre_oe", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
        scl = 1'b1; sda_m = 1'b1;
        #50 rst_n = 1'b1;
        #200;
        check("rst_post_state", {28'd0, state}, 32'd0);
        check("rst_post_outs", {24'd0, sda_oe, rx_valid, tx_load, nack, rw, busy, 2'b00}, 32'd0);
        check("rst_post_rx_data", {24'd0, rx_data}, 32'd0);
        check("oe_idle_wait_inv", cnt_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
